// File: rtl/stt_taint_tracker_if.sv
// ============================================================================
// Module      : stt_taint_tracker_if
// Description : Decode-group, visibility-point and query signals between the
//               load-dependency-graph stage and the STT taint tracker.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface stt_taint_tracker_if #(
  parameter int NUM_DECODE = 8,
  parameter int NUM_TAG    = 16,
  parameter int TAG_WIDTH  = $clog2(NUM_TAG)
);
  logic                                flush;
  logic                                grp_valid;
  logic                                grp_ready;
  logic [NUM_DECODE-1:0]               load_bit_vec;
  logic [(NUM_DECODE-1)*NUM_DECODE-1:0] load_depend_graph;
  logic                                out_valid;
  logic [NUM_DECODE*NUM_TAG-1:0]       out_taint;
  logic [NUM_DECODE*TAG_WIDTH-1:0]     out_tag;
  logic                                vp_valid;
  logic [TAG_WIDTH-1:0]                vp_tag;
  logic [NUM_TAG-1:0]                  query_mask;
  logic                                query_tainted;
  logic [TAG_WIDTH:0]                  free_count;

  // Decode-side driver (upstream stage / testbench)
  modport master (
    output flush, grp_valid, load_bit_vec, load_depend_graph,
           vp_valid, vp_tag, query_mask,
    input  grp_ready, out_valid, out_taint, out_tag, query_tainted, free_count
  );

  // Tracker side
  modport slave (
    input  flush, grp_valid, load_bit_vec, load_depend_graph,
           vp_valid, vp_tag, query_mask,
    output grp_ready, out_valid, out_taint, out_tag, query_tainted, free_count
  );
endinterface

`default_nettype wire

// File: rtl/stt_taint_tracker.sv
// ============================================================================
// Module      : stt_taint_tracker
// Description : Allocates taint tags to loads of an accepted decode group,
//               emits registered per-instruction taint masks, clears tags at
//               the visibility point, reclaims tags in order and answers
//               transmitter taint queries.
//               Optional macro STT_TAINT_BYPASS_EN: a same-cycle vp_tag is
//               already excluded from query_tainted and from tail reclaim.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module stt_taint_tracker #(
  parameter int NUM_DECODE = 8,
  parameter int NUM_TAG    = 16,
  parameter int TAG_WIDTH  = $clog2(NUM_TAG)
) (
  input  wire logic         clk,
  input  wire logic         reset,
  stt_taint_tracker_if.slave bus
);

  localparam int              CW        = TAG_WIDTH + 1;
  localparam logic [CW-1:0]   c_NUM_TAG = CW'(NUM_TAG);

  // Tag ring state
  logic [NUM_TAG-1:0]   r_pending;
  logic [TAG_WIDTH-1:0] r_head;
  logic [TAG_WIDTH-1:0] r_tail;
  logic [CW-1:0]        r_count;

  // Registered output bank
  logic                                     r_out_valid;
  logic [NUM_DECODE-1:0][NUM_TAG-1:0]       r_out_taint;
  logic [NUM_DECODE-1:0][TAG_WIDTH-1:0]     r_out_tag;

  // Combinational helpers
  logic [CW-1:0]                            w_pop;
  logic [CW-1:0]                            w_free;
  logic                                     w_ready;
  logic                                     w_accept;
  logic                                     w_reclaim;
  logic [NUM_TAG-1:0]                       w_vp_onehot;
  logic [NUM_TAG-1:0]                       w_pend_eff;
  logic [NUM_TAG-1:0]                       w_alloc;
  logic [TAG_WIDTH-1:0]                     w_tag [NUM_DECODE];
  logic [NUM_DECODE-1:0][TAG_WIDTH-1:0]     w_tag_out;
  logic [NUM_DECODE-1:0][NUM_TAG-1:0]       w_taint;

  // Hand out consecutive tags from head to loads in ascending slot order
  always_comb begin
    w_pop     = '0;
    w_alloc   = '0;
    w_tag_out = '0;
    for (int j = 0; j < NUM_DECODE; j++) begin
      w_tag[j] = r_head + w_pop[TAG_WIDTH-1:0];
      if (bus.load_bit_vec[j]) begin
        w_alloc[w_tag[j]] = 1'b1;
        w_tag_out[j]      = w_tag[j];
        w_pop             = w_pop + CW'(1);
      end
    end
  end

  // Taint mask of each instruction: own tag plus tags of older loads it depends on
  always_comb begin
    w_taint = '0;
    for (int i = 0; i < NUM_DECODE; i++) begin
      if (bus.load_bit_vec[i]) begin
        w_taint[i][w_tag[i]] = 1'b1;
      end
      for (int j = 0; j < i; j++) begin
        if (bus.load_depend_graph[(i-1)*NUM_DECODE + j] && bus.load_bit_vec[j]) begin
          w_taint[i][w_tag[j]] = 1'b1;
        end
      end
    end
  end

  // Capacity check, untaint view and in-order reclaim decision
  always_comb begin
    w_free      = c_NUM_TAG - r_count;
    w_ready     = ~bus.flush & ~reset & (w_free >= w_pop);
    w_accept    = bus.grp_valid & w_ready;
    w_vp_onehot = bus.vp_valid ? (NUM_TAG'(1) << bus.vp_tag) : '0;
`ifdef STT_TAINT_BYPASS_EN
    w_pend_eff  = r_pending & ~w_vp_onehot;
`else
    w_pend_eff  = r_pending;
`endif
    w_reclaim   = (r_count != '0) & ~w_pend_eff[r_tail];
  end

  // Tag ring and output bank update; flush outranks accept and untaint
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pending   <= '0;
      r_head      <= '0;
      r_tail      <= '0;
      r_count     <= '0;
      r_out_valid <= 1'b0;
      r_out_taint <= '0;
      r_out_tag   <= '0;
    end else if (bus.flush) begin
      r_pending   <= '0;
      r_head      <= '0;
      r_tail      <= '0;
      r_count     <= '0;
      r_out_valid <= 1'b0;
    end else begin
      // An allocated tag is always free this cycle, so it never collides with vp
      r_pending   <= (r_pending & ~w_vp_onehot) | (w_accept ? w_alloc : '0);
      if (w_accept) begin
        r_head      <= r_head + w_pop[TAG_WIDTH-1:0];
        r_out_taint <= w_taint;
        r_out_tag   <= w_tag_out;
      end
      if (w_reclaim) begin
        r_tail <= r_tail + TAG_WIDTH'(1);
      end
      r_count     <= r_count + (w_accept ? w_pop : '0) - (w_reclaim ? CW'(1) : '0);
      r_out_valid <= w_accept;
    end
  end

  assign bus.grp_ready     = w_ready;
  assign bus.out_valid     = r_out_valid;
  assign bus.out_taint     = r_out_taint;
  assign bus.out_tag       = r_out_tag;
  assign bus.query_tainted = |(bus.query_mask & w_pend_eff);
  assign bus.free_count    = w_free;

endmodule

`default_nettype wire

// File: tb/tb_stt_taint_tracker.sv
// ============================================================================
// Module      : tb_stt_taint_tracker
// Description : Directed self-checking bench for stt_taint_tracker with
//               NUM_DECODE=4, NUM_TAG=4; expected group results are queued
//               when a group is offered and compared when out_valid appears.
//               Honours STT_TAINT_BYPASS_EN for bypass-dependent expectations.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_stt_taint_tracker;

  localparam int ND = 4;
  localparam int NT = 4;
  localparam int TW = 2;

  typedef struct packed {
    logic [ND*NT-1:0] taint;
    logic [ND*TW-1:0] tag;
  } exp_t;

  logic clk;
  logic reset;
  int   checks;
  int   failures;
  exp_t sb[$];

  stt_taint_tracker_if #(.NUM_DECODE(ND), .NUM_TAG(NT), .TAG_WIDTH(TW)) bus ();

  stt_taint_tracker #(.NUM_DECODE(ND), .NUM_TAG(NT), .TAG_WIDTH(TW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  // Advance one clock and check the output bank against the scoreboard
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("out_valid", {31'd0, bus.out_valid}, 32'd1);
      chk("out_taint", {16'd0, bus.out_taint}, {16'd0, e.taint});
      chk("out_tag",   {24'd0, bus.out_tag},   {24'd0, e.tag});
    end else begin
      chk("out_valid_idle", {31'd0, bus.out_valid}, 32'd0);
    end
    bus.grp_valid = 1'b0;
    bus.vp_valid  = 1'b0;
    bus.flush     = 1'b0;
  endtask

  // Present a group, check readiness, queue the expected result if accepted
  task automatic offer(input logic [ND-1:0] lbv, input logic [(ND-1)*ND-1:0] dep,
                       input logic exp_ready, input logic [ND*NT-1:0] etaint,
                       input logic [ND*TW-1:0] etag);
    exp_t e;
    bus.grp_valid         = 1'b1;
    bus.load_bit_vec      = lbv;
    bus.load_depend_graph = dep;
    #1;
    chk("grp_ready", {31'd0, bus.grp_ready}, {31'd0, exp_ready});
    if (exp_ready) begin
      e.taint = etaint;
      e.tag   = etag;
      sb.push_back(e);
    end
  endtask

  task automatic chk_free(input int exp);
    chk("free_count", {29'd0, bus.free_count}, exp[31:0]);
  endtask

  task automatic chk_query(input logic [NT-1:0] m, input logic exp);
    bus.query_mask = m;
    #1;
    chk("query_tainted", {31'd0, bus.query_tainted}, {31'd0, exp});
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    bus.flush             = 1'b0;
    bus.grp_valid         = 1'b0;
    bus.load_bit_vec      = '0;
    bus.load_depend_graph = '0;
    bus.vp_valid          = 1'b0;
    bus.vp_tag            = '0;
    bus.query_mask        = '0;

    // Reset and idle
    tick();
    tick();
    #1;
    chk("grp_ready_in_reset", {31'd0, bus.grp_ready}, 32'd0);
    reset = 1'b0;
    tick();
    chk_free(4);
    chk_query(4'b1111, 1'b0);

    // Group 0101: instr1<-load0, instr3<-load0,load2
    offer(4'b0101, 12'h501, 1'b1, 16'h3211, 8'h10);
    tick();
    chk_free(2);
    chk_query(4'b1111, 1'b1);

    // Three loads with two free tags: stalled
    offer(4'b0111, 12'h000, 1'b0, '0, '0);
    tick();
    chk_free(2);
    bus.load_bit_vec = 4'b0011;
    #1;
    chk("grp_ready_fit", {31'd0, bus.grp_ready}, 32'd1);
    bus.load_bit_vec = 4'b0000;

    // Untaint tag 1 with a same-cycle query on it
    bus.vp_valid = 1'b1;
    bus.vp_tag   = 2'd1;
`ifdef STT_TAINT_BYPASS_EN
    chk_query(4'b0010, 1'b0);
`else
    chk_query(4'b0010, 1'b1);
`endif
    tick();
    chk_free(2);
    chk_query(4'b0010, 1'b0);
    chk_query(4'b0001, 1'b1);

    // Untaint tag 0: in-order reclaim of 0 then 1
    bus.vp_valid = 1'b1;
    bus.vp_tag   = 2'd0;
    tick();
`ifdef STT_TAINT_BYPASS_EN
    chk_free(3);
`else
    chk_free(2);
`endif
    tick();
`ifdef STT_TAINT_BYPASS_EN
    chk_free(4);
`else
    chk_free(3);
`endif
    tick();
    chk_free(4);
    chk_query(4'b1111, 1'b0);

    // Allocate one load at head=2, then flush with grp and vp in the same cycle
    offer(4'b1000, 12'h000, 1'b1, 16'h4000, 8'h80);
    tick();
    chk_free(3);
    bus.flush    = 1'b1;
    bus.vp_valid = 1'b1;
    bus.vp_tag   = 2'd2;
    offer(4'b0001, 12'h000, 1'b0, '0, '0);
    tick();
    chk_free(4);
    chk_query(4'b1111, 1'b0);

    // Wrap-around: allocate 3 from head 0, untaint and reclaim all
    offer(4'b0111, 12'h120, 1'b1, 16'h1621, 8'h24);
    tick();
    chk_free(1);
    chk_query(4'b0111, 1'b1);
    for (int t = 0; t < 3; t++) begin
      bus.vp_valid = 1'b1;
      bus.vp_tag   = TW'(t);
      tick();
    end
    tick();
    tick();
    chk_free(4);

    // Two loads from head 3: tags 3 and 0, instr3<-load0
    offer(4'b1001, 12'h100, 1'b1, 16'h9008, 8'h03);
    tick();
    chk_free(2);
    chk_query(4'b1001, 1'b1);
    chk_query(4'b0110, 1'b0);
    bus.load_bit_vec = 4'b0111;
    #1;
    chk("grp_ready_full", {31'd0, bus.grp_ready}, 32'd0);

    // Reset mid-operation with a group offered
    reset = 1'b1;
    offer(4'b0001, 12'h000, 1'b0, '0, '0);
    tick();
    chk_free(4);
    reset = 1'b0;
    tick();
    chk_query(4'b1111, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/stt_taint_tracker.md
# stt_taint_tracker

Sequential taint tracker for the STT decode path: the consumer side of the load dependency graph. It sits after the load-dependency-graph stage at rename/decode. It assigns a taint tag to every load in an accepted decode group and emits a registered per-instruction taint mask over in-flight load tags. It also clears tags when loads reach their visibility point, reclaims tags in order, and answers taint queries from transmitter instructions.

## Interface
Parameters:
- NUM_DECODE, 8, instructions per decode group.
- NUM_TAG, 16, load taint tags in flight; power of two, ≥ NUM_DECODE.
- TAG_WIDTH, $clog2(NUM_TAG), tag index width.

Ports (one clock; reset is synchronous and active-high):
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- flush  input  1  squash of all in-flight state.
- grp_valid  input  1  decode group offered.
- grp_ready  output  1  group can be accepted.
- load_bit_vec  input  NUM_DECODE  bit j set means instr j is a load.
- load_depend_graph  input  (NUM_DECODE-1)*NUM_DECODE  flattened.
  - Bit (i-1)*NUM_DECODE+j means instr i (1..NUM_DECODE-1) transitively depends on load j<i.
  - Bits with j≥i are ignored.
- out_valid  output  1  taint result valid.
- out_taint  output  NUM_DECODE*NUM_TAG  slice i is the taint mask of instr i.
- out_tag  output  NUM_DECODE*TAG_WIDTH  slice j is the tag of load j; zero for non-loads.
- vp_valid  input  1  a load reached its visibility point.
- vp_tag  input  TAG_WIDTH  tag to untaint.
- query_mask  input  NUM_TAG  taint mask of a transmitter.
- query_tainted  output  1  |(query_mask & pending).
- free_count  output  TAG_WIDTH+1  unallocated tags.

## Operation
State:
- pending[NUM_TAG]: load not yet visible.
- head: allocation pointer.
- tail: oldest allocated tag.
- count: allocated tags, 0..NUM_TAG.
- Registered output bank.

Handshake and ready:
- Accept = grp_valid & grp_ready.
- grp_ready = ~flush & ~reset & (NUM_TAG − count ≥ popcount(load_bit_vec)).
- grp_ready is combinational from load_bit_vec, by design.

On accept:
- Loads in ascending j receive tags head, head+1, …, mod NUM_TAG (wrap-around).
- pending is set for each allocated tag.
- head += popcount; count += popcount.
- Taint mask of instr i = OR over j<i of (dep(i,j) & load_j ? onehot(tag_j) : 0), OR onehot(tag_i) if instr i is itself a load.
- Instr 0's mask is its own tag if it is a load, else zero.
- A group with no loads is accepted and produces all-zero masks.

Untaint:
- On vp_valid, pending[vp_tag] is cleared.
- vp_valid on an unallocated or already-clear tag has no effect.

Reclaim:
- Each cycle, if count>0 and pending[tail]==0: tail+1, count−1. At most one tag per cycle.
- Reclaim capacity is visible in grp_ready next cycle.

Simultaneous events:
- accept, vp, and reclaim in the same cycle all apply.
- Net count = count + popcount − reclaim.
- vp cannot target a tag being allocated, since that tag is free.

Flush:
- Highest priority.
- Clears pending, head, tail, count, and out_valid.
- Ignores grp and vp in the same cycle.

## Timing
- Reset values:
  - grp_ready=0 during reset.
  - out_valid=0, out_taint=0, out_tag=0.
  - pending=0, head=tail=count=0, free_count=NUM_TAG.
  - query_tainted=0.
- Latency:
  - out_valid, out_taint, and out_tag are registered one cycle after accept.
  - out_valid is high for exactly one cycle per accepted group.
  - out_valid is zero on cycles with no accept.
- query_tainted is combinational from query_mask and registered pending (see Configuration).
- free_count = NUM_TAG − count, from registers.
- Reset or flush mid-operation: in-flight output is dropped (out_valid=0 next cycle) and all tags become free.

## Configuration
- STT_TAINT_BYPASS_EN defined:
  - query_tainted also excludes a same-cycle vp_tag: |(query_mask & pending & ~(vp_valid ? onehot(vp_tag) : 0)).
  - Reclaim of tail also sees a same-cycle vp_tag==tail.
- Undefined:
  - Untaint is visible to query and reclaim only from the next cycle.

## Test plan
(NUM_DECODE=4, NUM_TAG=4)
- Reset, then idle: free_count=4, out_valid=0, query_mask=4'b1111 -> query_tainted=0.
- Group with load_bit_vec=4'b0101, instr3 depends on load0 and load2, instr1 on load0, after reset -> next cycle:
  - out_tag: load0=0, load2=1.
  - out_taint masks: instr0=0001, instr1=0001, instr2=0010, instr3=0011.
  - free_count=2.
- Same state plus load_bit_vec=4'b0111 (3 loads, 2 free) -> grp_ready=0, nothing allocated.
- vp_tag=1, then vp_tag=0 -> tail reclaims tag 0, then tag 1, over the following cycles; free_count returns to 4.
  - With the macro: query_mask=0010 in the same cycle as vp_tag=1 -> query_tainted=0.
  - Without the macro: query_tainted=1 that cycle.
- Wrap-around: allocate 3, untaint and reclaim all, then allocate 2 loads -> tags 3 and 0.
- flush asserted together with grp_valid and vp_valid -> next cycle out_valid=0, free_count=4, pending all clear.
